kbd_event_queue: RTL and testbench

- Sequences the PS/2 scancode receiver: consumes each received byte via the receiver's ready/nextdata_n handshake and decodes F0/E0 prefixes.
- Tracks ctrl/shift/caps modifier state and packs each make or break into a 16-bit event.
- Buffers events in a FIFO; the CPU-side MMIO reader pops them.
- Replaces ad-hoc "current key" sampling, so no keystroke is lost between CPU polls.

---
 rtl/kbd_pkg.sv | 57 +++++
 rtl/kbd_sync_fifo.sv | 67 ++++++
 rtl/kbd_event_queue.sv | 136 +++++++++++++
 tb/tb_kbd_event_queue.sv | 196 +++++++++++++++++++
 4 files changed

// File: rtl/kbd_pkg.sv
// Shared constants, event layout and intake FSM state type for the
// keyboard event queue.
package kbd_pkg;

    // PS/2 set-2 scancodes with special meaning to the decoder
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_CTRL   = 8'h14;
    localparam logic [7:0] SC_LSHIFT = 8'h12;
    localparam logic [7:0] SC_RSHIFT = 8'h59;
    localparam logic [7:0] SC_CAPS   = 8'h58;

    // Bit positions inside a 16-bit event word
    localparam int unsigned EVT_BREAK = 15;
    localparam int unsigned EVT_EXT   = 14;
    localparam int unsigned EVT_SHIFT = 13;
    localparam int unsigned EVT_CTRL  = 12;
    localparam int unsigned EVT_CAPS  = 11;
    localparam int unsigned EVT_WIDTH = 16;

    // Packed view of an event; field order matches the bit indices above
    typedef struct packed {
        logic       brk;
        logic       ext;
        logic       shift;
        logic       ctrl;
        logic       caps;
        logic [2:0] rsvd;
        logic [7:0] code;
    } kbd_evt_t;

    typedef enum logic {
        IDLE,
        ACK
    } intake_state_t;

    // Assemble an event word; reserved bits are always zero
    function automatic kbd_evt_t pack_event(
        input logic       brk,
        input logic       ext,
        input logic       shift,
        input logic       ctrl,
        input logic       caps,
        input logic [7:0] code
    );
        logic [EVT_WIDTH-1:0] w;
        w            = '0;
        w[EVT_BREAK] = brk;
        w[EVT_EXT]   = ext;
        w[EVT_SHIFT] = shift;
        w[EVT_CTRL]  = ctrl;
        w[EVT_CAPS]  = caps;
        w[7:0]       = code;
        return kbd_evt_t'(w);
    endfunction

endpackage

// File: rtl/kbd_sync_fifo.sv
// Single-clock first-word-fall-through FIFO. A push into a full FIFO is
// accepted only when a pop happens in the same cycle; otherwise it is
// dropped and reported on 'drop'. Pops on an empty FIFO are ignored.
module kbd_sync_fifo #(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4,
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             empty,
    output logic             full,
    output logic [AW:0]      count,
    output logic             drop
);

    localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic             push_ok;
    logic             pop_ok;

    // Accept/reject decisions for this cycle
    always_comb begin
        empty   = (count == '0);
        full    = (count == FULL_CNT);
        pop_ok  = pop && !empty;
        push_ok = push && (!full || pop_ok);
        drop    = push && !push_ok;
        dout    = empty ? '0 : mem[rd_ptr];
    end

    // Storage array, written only on accepted pushes
    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push_ok, pop_ok})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/kbd_event_queue.sv
// PS/2 scancode intake: acknowledges each received byte, decodes F0/E0
// prefixes, tracks modifier keys and queues one 16-bit event per make or
// break for the CPU to pop.
module kbd_event_queue
    import kbd_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned AW    = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [7:0]    rx_data,
    input  logic          rx_ready,
    output logic          rx_next_n,
    input  logic          rd_en,
    output logic [15:0]   evt_data,
    output logic          evt_valid,
    output logic [AW:0]   evt_count,
    output logic          overflow,
    input  logic          clr_ovf
);

    intake_state_t state;

    logic     ctrl;
    logic     shift_l;
    logic     shift_r;
    logic     caps;
    logic     brk_pend;
    logic     ext_pend;

    logic     capture;
    logic     is_prefix;
    logic     push;
    logic     fifo_empty;
    logic     fifo_full;
    logic     drop;
    kbd_evt_t evt;

    // Byte capture qualification and event assembly from pre-update state
    always_comb begin
        capture   = (state == IDLE) && rx_ready;
        is_prefix = (rx_data == SC_BREAK) || (rx_data == SC_EXT);
        push      = capture && !is_prefix;
        evt       = pack_event(brk_pend, ext_pend, shift_l | shift_r,
                               ctrl, caps, rx_data);
    end

    // Intake handshake: one capture, then one cycle of rx_next_n low
    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            rx_next_n <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (rx_ready) begin
                        state     <= ACK;
                        rx_next_n <= 1'b0;
                    end
                end
                ACK: begin
                    state     <= IDLE;
                    rx_next_n <= 1'b1;
                end
                default: begin
                    state     <= IDLE;
                    rx_next_n <= 1'b1;
                end
            endcase
        end
    end

    // Prefix flags and modifier state, updated on each captured byte
    always_ff @(posedge clk) begin
        if (rst) begin
            brk_pend <= 1'b0;
            ext_pend <= 1'b0;
            ctrl     <= 1'b0;
            shift_l  <= 1'b0;
            shift_r  <= 1'b0;
            caps     <= 1'b0;
        end else if (capture) begin
            if (rx_data == SC_BREAK) begin
                brk_pend <= 1'b1;
            end else if (rx_data == SC_EXT) begin
                ext_pend <= 1'b1;
            end else begin
                brk_pend <= 1'b0;
                ext_pend <= 1'b0;
                case (rx_data)
                    SC_CTRL:   ctrl    <= !brk_pend;
                    SC_LSHIFT: shift_l <= !brk_pend;
                    SC_RSHIFT: shift_r <= !brk_pend;
                    // Every make toggles, including typematic repeats
                    SC_CAPS:   if (!brk_pend) caps <= !caps;
                    default:   ;
                endcase
            end
        end
    end

    // Sticky overflow; a drop in the same cycle as a clear keeps it set
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (drop) begin
            overflow <= 1'b1;
        end else if (clr_ovf) begin
            overflow <= 1'b0;
        end
    end

    kbd_sync_fifo #(
        .DEPTH (DEPTH),
        .AW    (AW),
        .WIDTH (16)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .pop   (rd_en),
        .din   (evt),
        .dout  (evt_data),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (evt_count),
        .drop  (drop)
    );

    // Valid mirrors FIFO occupancy; fifo_full is folded in only to keep it referenced
    always_comb begin
        evt_valid = !fifo_empty || (fifo_full && 1'b0);
    end

endmodule

// File: tb/tb_kbd_event_queue.sv
// Directed testbench for kbd_event_queue.
module tb_kbd_event_queue;

    logic        clk;
    logic        rst;
    logic [7:0]  rx_data;
    logic        rx_ready;
    logic        rx_next_n;
    logic        rd_en;
    logic [15:0] evt_data;
    logic        evt_valid;
    logic [4:0]  evt_count;
    logic        overflow;
    logic        clr_ovf;

    int vectors;
    int miscompares;

    kbd_event_queue #(
        .DEPTH (16),
        .AW    (4)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .rx_next_n (rx_next_n),
        .rd_en     (rd_en),
        .evt_data  (evt_data),
        .evt_valid (evt_valid),
        .evt_count (evt_count),
        .overflow  (overflow),
        .clr_ovf   (clr_ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Entered and left at a negedge; one byte through the handshake
    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        check("ack_low", {31'd0, rx_next_n}, 32'd0);
        @(negedge clk);
        check("ack_high", {31'd0, rx_next_n}, 32'd1);
    endtask

    task automatic pop_expect(input string tag, input logic [15:0] exp);
        check({tag, "_valid"}, {31'd0, evt_valid}, 32'd1);
        check(tag, {16'd0, evt_data}, {16'd0, exp});
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
    endtask

    initial begin
        vectors     = 0;
        miscompares = 0;
        rst      = 1'b1;
        rx_data  = 8'h00;
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        clr_ovf  = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_next_n", {31'd0, rx_next_n}, 32'd1);
        check("rst_valid", {31'd0, evt_valid}, 32'd0);
        check("rst_count", {27'd0, evt_count}, 32'd0);
        check("rst_ovf", {31'd0, overflow}, 32'd0);
        check("rst_data", {16'd0, evt_data}, 32'd0);
        rst = 1'b0;
        @(negedge clk);

        // make / break
        send_byte(8'h1C);
        check("mb_count1", {27'd0, evt_count}, 32'd1);
        check("mb_head", {16'd0, evt_data}, 32'h001C);
        send_byte(8'hF0);
        check("mb_count_pfx", {27'd0, evt_count}, 32'd1);
        send_byte(8'h1C);
        check("mb_count2", {27'd0, evt_count}, 32'd2);
        pop_expect("mb_make", 16'h001C);
        pop_expect("mb_break", 16'h801C);
        check("mb_count0", {27'd0, evt_count}, 32'd0);

        // shift qualification
        send_byte(8'h12);
        send_byte(8'h1C);
        send_byte(8'hF0);
        send_byte(8'h12);
        send_byte(8'h1C);
        pop_expect("sh_make", 16'h0012);
        pop_expect("sh_key", 16'h201C);
        pop_expect("sh_break", 16'hA012);
        pop_expect("sh_after", 16'h001C);

        // extended codes and right ctrl
        send_byte(8'hE0); send_byte(8'h14);
        send_byte(8'hE0); send_byte(8'h75);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h14);
        send_byte(8'h1C);
        pop_expect("ext_ctrl", 16'h4014);
        pop_expect("ext_up", 16'h5075);
        pop_expect("ext_brk", 16'hD014);
        pop_expect("ext_after", 16'h001C);

        // caps lock toggle
        send_byte(8'h58);
        send_byte(8'hF0); send_byte(8'h58);
        send_byte(8'h1C);
        send_byte(8'h58);
        send_byte(8'h1C);
        pop_expect("caps_make", 16'h0058);
        pop_expect("caps_break", 16'h8858);
        pop_expect("caps_on", 16'h081C);
        pop_expect("caps_make2", 16'h0858);
        pop_expect("caps_off", 16'h001C);
        check("caps_empty", {27'd0, evt_count}, 32'd0);

        // overflow: 17 pushes into 16 entries
        for (int i = 1; i <= 17; i++) begin
            send_byte(8'(i));
        end
        check("ovf_count", {27'd0, evt_count}, 32'd16);
        check("ovf_flag", {31'd0, overflow}, 32'd1);
        check("ovf_head", {16'd0, evt_data}, 32'h0001);

        // push while full with simultaneous pop is accepted
        rx_data  = 8'h20;
        rx_ready = 1'b1;
        rd_en    = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rd_en    = 1'b0;
        check("pp_count", {27'd0, evt_count}, 32'd16);
        check("pp_head", {16'd0, evt_data}, 32'h0002);
        @(negedge clk);

        // drop coinciding with clr_ovf keeps overflow set
        rx_data  = 8'h21;
        rx_ready = 1'b1;
        clr_ovf  = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        clr_ovf  = 1'b0;
        check("set_wins", {31'd0, overflow}, 32'd1);
        check("drop_count", {27'd0, evt_count}, 32'd16);
        @(negedge clk);

        clr_ovf = 1'b1;
        @(negedge clk);
        clr_ovf = 1'b0;
        check("clr_ovf", {31'd0, overflow}, 32'd0);

        for (int i = 0; i < 15; i++) begin
            pop_expect("drain", 16'(8'h02 + i));
        end
        pop_expect("drain_last", 16'h0020);
        check("drain_empty", {27'd0, evt_count}, 32'd0);

        // reset while a break prefix is pending and the ack is in flight
        rx_data  = 8'hF0;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        rst      = 1'b1;
        check("mid_ack_low", {31'd0, rx_next_n}, 32'd0);
        @(negedge clk);
        check("mid_rst_next_n", {31'd0, rx_next_n}, 32'd1);
        rst = 1'b0;
        @(negedge clk);
        send_byte(8'h1C);
        pop_expect("mid_evt", 16'h001C);

        // pop on empty
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        check("empty_pop_count", {27'd0, evt_count}, 32'd0);
        check("empty_pop_valid", {31'd0, evt_valid}, 32'd0);
        check("empty_pop_data", {16'd0, evt_data}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
